host_rr_arbiter: RTL and testbench
==================================

# host_rr_arbiter

Round-robin arbiter that shares one Ibex-style req/gnt/rvalid device port among `NrHosts` bus hosts, for example core data, debug SBA and a future DMA engine onto a single RAM port. Grants are fair and in request order, and a stalled request is held stable until the device accepts it. In-order responses are routed back to the issuing host through an ID FIFO. The block sits between the hosts and a single device, in front of or in place of a direct host connection.

## Interface
Parameters:
- `NrHosts`, default 2: number of hosts, at least 2.
- `AddrWidth`, default 32: address width.
- `DataWidth`, default 32: data width. Byte enables are `DataWidth/8` bits.
- `MaxOutstanding`, default 2: maximum accepted but unanswered requests, at least 1.

Ports:
- `clk_i` in 1: system clock.
- `rst_ni` in 1: reset. One clock; reset is asynchronous and active-low.
- `host_req_i` in `[NrHosts]` x 1: host request.
- `host_gnt_o` out `[NrHosts]` x 1: host grant.
- `host_addr_i`, `host_we_i`, `host_be_i`, `host_wdata_i` in `[NrHosts]` x `AddrWidth`/1/`DataWidth/8`/`DataWidth`: request payload.
- `host_rvalid_o` out `[NrHosts]` x 1: response valid, one-hot.
- `host_rdata_o`, `host_err_o` out `[NrHosts]` x `DataWidth`/1: response data and error, broadcast to every host.
- `dev_req_o` out 1: device request.
- `dev_gnt_i` in 1: device grant.
- `dev_addr_o`, `dev_we_o`, `dev_be_o`, `dev_wdata_o` out: payload of the selected host.
- `dev_rvalid_i` in 1: device response valid.
- `dev_rdata_i` in `DataWidth`: device response data.
- `dev_err_i` in 1: device response error.
- `spurious_rsp_o` out 1: one-cycle pulse when `dev_rvalid_i` arrives while the FIFO is empty.

## Operation
- **Priority pointer `ptr`:**
  - `ptr` is in the range 0..NrHosts-1 and resets to 0.
  - Selection `sel` is the first requesting host scanning `ptr`, `ptr+1`, … modulo NrHosts.
- **Lock:**
  - If `dev_req_o` is high and `dev_gnt_i` is low, register `lock=1` and `lock_id=sel`.
  - While `lock=1`, `sel` is forced to `lock_id` regardless of other requests.
  - `lock` clears on the cycle the grant occurs.
  - Hosts must hold req and payload until gnt, which is the existing bus rule.
- **Request path:**
  - `full = (count == MaxOutstanding)`.
  - `dev_req_o = |host_req_i & ~full`.
  - `dev_*` payload equals `host_*[sel]`.
  - When no host is requesting, the payload is don't-care and is driven as host 0's.
- **Grant:**
  - `host_gnt_o[sel] = dev_req_o & dev_gnt_i`. All other gnt bits are 0.
  - On a grant, `ptr <= (sel+1) mod NrHosts`, `sel` is pushed to the ID FIFO, and `count` increments.
- **Response:**
  - On `dev_rvalid_i` with `count>0`: `host_rvalid_o[fifo_head]=1` in the same cycle, then pop and decrement `count`.
  - `host_rdata_o`/`host_err_o` for every host equal `dev_rdata_i`/`dev_err_i`.
- **Simultaneous grant and response:** push and pop happen together and `count` is unchanged.
- **`full` is based on the registered `count` only:**
  - A same-cycle pop does not unblock a grant.
  - This gives no combinational path from `dev_rvalid_i` to `dev_req_o`.
- **Empty FIFO:**
  - `dev_rvalid_i` with `count==0` is dropped.
  - No `host_rvalid_o` is raised and `spurious_rsp_o` pulses.
- **ID FIFO:**
  - Circular buffer of depth `MaxOutstanding` with entries `$clog2(NrHosts)` wide.
  - Read and write pointers wrap modulo the depth.
  - `count` is `$clog2(MaxOutstanding+1)` bits wide.

## Timing
- Arbitration and response routing are combinational, with zero added latency.
- A request granted in cycle N has its response routed in the cycle the device returns it.
- `ptr`, `lock`, `lock_id`, the FIFO pointers and `count` are registered.
- Reset values:
  - `ptr=0`, `lock=0`, `count=0`, FIFO empty.
  - `dev_req_o=0`, all `host_gnt_o=0`, all `host_rvalid_o=0`, `spurious_rsp_o=0`.
- **Reset mid-operation:**
  - All state clears asynchronously.
  - In-flight responses arriving after reset release pulse `spurious_rsp_o` and are not forwarded.

## Test plan
- **Single host:** host0 req at 0x00100010, `dev_gnt_i=1`, rvalid one cycle later with rdata=0xDEADBEEF.
  - `host_gnt_o=2'b01` in the same cycle.
  - `host_rvalid_o[0]=1` with data 0xDEADBEEF.
  - `ptr=1` afterwards.
- **Contention:** both hosts request continuously with `dev_gnt_i=1`.
  - Grants alternate 0,1,0,1.
  - rvalid is routed to 0,1,0,1 in order.
- **Stall lock:** host1 requests with `dev_gnt_i=0` for 3 cycles while `ptr=0`, and host0 raises req in cycle 2.
  - `dev_addr_o` stays at host1's address.
  - gnt goes to host1 when `dev_gnt_i` rises.
  - host0 is granted next.
- **Full:** MaxOutstanding=2, two grants with no responses.
  - `dev_req_o=0` despite a pending req.
  - When the first rvalid arrives, `dev_req_o` reasserts in the following cycle.
- **Simultaneous push and pop at count=1:** grant and rvalid occur in the same cycle.
  - `count` stays at 1.
  - The response goes to the older ID.
- **Spurious and reset:** rvalid while empty, then reset asserted with 2 outstanding.
  - `spurious_rsp_o` pulses once and no `host_rvalid_o` is raised.
  - After reset, `count=0` and `ptr=0`, and a late rvalid pulses `spurious_rsp_o`.

Source files
------------

// File: rtl/host_rr_arbiter.sv
// rtl/host_rr_arbiter.sv - round-robin req/gnt/rvalid arbiter with in-order response routing
//
// Shares one Ibex-style device port among NrHosts hosts.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   host_req_i/host_gnt_o  per-host request / grant
//   host_addr_i, host_we_i, host_be_i, host_wdata_i   per-host request payload
//   host_rvalid_o          one-hot response valid toward the issuing host
//   host_rdata_o/host_err_o response data/error, broadcast to every host
//   dev_req_o/dev_gnt_i    device request / grant
//   dev_addr_o, dev_we_o, dev_be_o, dev_wdata_o       payload of the selected host
//   dev_rvalid_i, dev_rdata_i, dev_err_i              device response
//   spurious_rsp_o         device response while nothing is outstanding
module host_rr_arbiter #(
  parameter int NrHosts        = 2,
  parameter int AddrWidth      = 32,
  parameter int DataWidth      = 32,
  parameter int MaxOutstanding = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NrHosts-1:0]     host_req_i,
  output logic [NrHosts-1:0]     host_gnt_o,
  input  logic [AddrWidth-1:0]   host_addr_i  [NrHosts],
  input  logic [NrHosts-1:0]     host_we_i,
  input  logic [DataWidth/8-1:0] host_be_i    [NrHosts],
  input  logic [DataWidth-1:0]   host_wdata_i [NrHosts],
  output logic [NrHosts-1:0]     host_rvalid_o,
  output logic [DataWidth-1:0]   host_rdata_o [NrHosts],
  output logic [NrHosts-1:0]     host_err_o,
  output logic                   dev_req_o,
  input  logic                   dev_gnt_i,
  output logic [AddrWidth-1:0]   dev_addr_o,
  output logic                   dev_we_o,
  output logic [DataWidth/8-1:0] dev_be_o,
  output logic [DataWidth-1:0]   dev_wdata_o,
  input  logic                   dev_rvalid_i,
  input  logic [DataWidth-1:0]   dev_rdata_i,
  input  logic                   dev_err_i,
  output logic                   spurious_rsp_o
);

  localparam int PtrW   = $clog2(NrHosts);
  localparam int CntW   = $clog2(MaxOutstanding + 1);
  localparam int FifoAw = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  localparam logic [PtrW-1:0]   LastHost = PtrW'(NrHosts - 1);
  localparam logic [FifoAw-1:0] FifoLast = FifoAw'(MaxOutstanding - 1);
  localparam logic [CntW-1:0]   CntMax   = CntW'(MaxOutstanding);

  logic [PtrW-1:0]   ptr_q;
  logic              lock_q;
  logic [PtrW-1:0]   lock_id_q;
  logic [CntW-1:0]   count_q;
  logic [FifoAw-1:0] wr_ptr_q;
  logic [FifoAw-1:0] rd_ptr_q;
  logic [PtrW-1:0]   fifo_q [MaxOutstanding];

  logic [PtrW-1:0]   scan_sel;
  logic [PtrW:0]     cand;
  logic [PtrW-1:0]   sel;
  logic [PtrW-1:0]   fifo_head;
  logic              full;
  logic              grant;
  logic              pop;

  function automatic logic [FifoAw-1:0] fifo_inc(input logic [FifoAw-1:0] p);
    return (p == FifoLast) ? '0 : p + 1'b1;
  endfunction

  // Scan from ptr upward, modulo NrHosts. Iterating from the farthest offset
  // down lets the nearest requester overwrite the result last and win.
  always_comb begin
    scan_sel = '0;
    cand     = '0;
    for (int i = NrHosts - 1; i >= 0; i--) begin
      cand = {1'b0, ptr_q} + (PtrW + 1)'(i);
      if (cand >= (PtrW + 1)'(NrHosts)) begin
        cand = cand - (PtrW + 1)'(NrHosts);
      end
      if (host_req_i[cand[PtrW-1:0]]) begin
        scan_sel = cand[PtrW-1:0];
      end
    end
  end

  // A stalled request keeps its host selected so the device sees a stable
  // payload even if a higher-priority host starts requesting meanwhile.
  assign sel       = lock_q ? lock_id_q : scan_sel;
  assign full      = (count_q == CntMax);
  assign dev_req_o = (|host_req_i) & ~full;
  assign grant     = dev_req_o & dev_gnt_i;
  assign fifo_head = fifo_q[rd_ptr_q];
  assign pop       = dev_rvalid_i & (count_q != '0);

  assign spurious_rsp_o = dev_rvalid_i & (count_q == '0);

  assign dev_addr_o  = host_addr_i[sel];
  assign dev_we_o    = host_we_i[sel];
  assign dev_be_o    = host_be_i[sel];
  assign dev_wdata_o = host_wdata_i[sel];

  always_comb begin
    host_gnt_o    = '0;
    host_rvalid_o = '0;
    host_err_o    = '0;
    for (int i = 0; i < NrHosts; i++) begin
      host_gnt_o[i]    = grant & (sel == PtrW'(i));
      host_rvalid_o[i] = pop & (fifo_head == PtrW'(i));
      host_err_o[i]    = dev_err_i;
      host_rdata_o[i]  = dev_rdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q     <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      for (int i = 0; i < MaxOutstanding; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      if (grant) begin
        lock_q           <= 1'b0;
        ptr_q            <= (sel == LastHost) ? '0 : sel + 1'b1;
        fifo_q[wr_ptr_q] <= sel;
        wr_ptr_q         <= fifo_inc(wr_ptr_q);
      end else if (dev_req_o) begin
        lock_q    <= 1'b1;
        lock_id_q <= sel;
      end

      if (pop) begin
        rd_ptr_q <= fifo_inc(rd_ptr_q);
      end

      if (grant && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (!grant && pop) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_host_rr_arbiter.sv
// tb/tb_host_rr_arbiter.sv - scoreboard bench for host_rr_arbiter
module tb_host_rr_arbiter;

  localparam logic [31:0] Addr0 = 32'h0010_0010;
  localparam logic [31:0] Addr1 = 32'h0020_0020;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [1:0]  host_req_i = '0;
  logic [1:0]  host_gnt_o;
  logic [31:0] host_addr_i [2];
  logic [1:0]  host_we_i = 2'b10;
  logic [3:0]  host_be_i [2];
  logic [31:0] host_wdata_i [2];
  logic [1:0]  host_rvalid_o;
  logic [31:0] host_rdata_o [2];
  logic [1:0]  host_err_o;
  logic        dev_req_o;
  logic        dev_gnt_i = 1'b0;
  logic [31:0] dev_addr_o;
  logic        dev_we_o;
  logic [3:0]  dev_be_o;
  logic [31:0] dev_wdata_o;
  logic        dev_rvalid_i = 1'b0;
  logic [31:0] dev_rdata_i = '0;
  logic        dev_err_i = 1'b0;
  logic        spurious_rsp_o;

  host_rr_arbiter #(
    .NrHosts(2), .AddrWidth(32), .DataWidth(32), .MaxOutstanding(2)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .host_req_i(host_req_i), .host_gnt_o(host_gnt_o),
    .host_addr_i(host_addr_i), .host_we_i(host_we_i),
    .host_be_i(host_be_i), .host_wdata_i(host_wdata_i),
    .host_rvalid_o(host_rvalid_o), .host_rdata_o(host_rdata_o),
    .host_err_o(host_err_o),
    .dev_req_o(dev_req_o), .dev_gnt_i(dev_gnt_i),
    .dev_addr_o(dev_addr_o), .dev_we_o(dev_we_o),
    .dev_be_o(dev_be_o), .dev_wdata_o(dev_wdata_o),
    .dev_rvalid_i(dev_rvalid_i), .dev_rdata_i(dev_rdata_i),
    .dev_err_i(dev_err_i), .spurious_rsp_o(spurious_rsp_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          host;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  int   exp_gnt [$];
  rsp_t exp_rsp [$];
  int   tests = 0;
  int   fails = 0;
  int   spur_seen = 0;
  int   spur_exp = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_rsp(input int host, input logic [31:0] data, input logic err);
    rsp_t r;
    r.host = host;
    r.data = data;
    r.err  = err;
    exp_rsp.push_back(r);
  endtask

  // Monitor: samples on the falling edge, pops expectations whenever the
  // DUT presents a grant or a response.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (host_gnt_o != 2'b00) begin
        tests++;
        if (exp_gnt.size() == 0) begin
          fails++;
          $display("FAIL gnt_unexpected: got %b expected none", host_gnt_o);
        end else begin
          int e;
          e = exp_gnt.pop_front();
          if (host_gnt_o != (2'b01 << e)) begin
            fails++;
            $display("FAIL gnt_route: got %b expected host %0d", host_gnt_o, e);
          end
        end
      end
      if (host_rvalid_o != 2'b00) begin
        tests++;
        if (exp_rsp.size() == 0) begin
          fails++;
          $display("FAIL rvalid_unexpected: got %b expected none", host_rvalid_o);
        end else begin
          rsp_t r;
          r = exp_rsp.pop_front();
          if (host_rvalid_o != (2'b01 << r.host) || host_rdata_o[r.host] !== r.data
              || host_err_o[r.host] !== r.err) begin
            fails++;
            $display("FAIL rsp_route: got rvalid=%b data=0x%0h err=%b expected host %0d data=0x%0h err=%b",
                     host_rvalid_o, host_rdata_o[r.host], host_err_o[r.host], r.host, r.data, r.err);
          end
        end
      end
      if (spurious_rsp_o) spur_seen++;
    end
  end

  initial begin
    host_addr_i[0]  = Addr0;
    host_addr_i[1]  = Addr1;
    host_be_i[0]    = 4'hF;
    host_be_i[1]    = 4'h3;
    host_wdata_i[0] = 32'h1111_0000;
    host_wdata_i[1] = 32'h2222_0000;

    // Reset state
    #3;
    check("rst_dev_req", {31'd0, dev_req_o}, 32'd0);
    check("rst_gnt", {30'd0, host_gnt_o}, 32'd0);
    check("rst_rvalid", {30'd0, host_rvalid_o}, 32'd0);
    check("rst_spurious", {31'd0, spurious_rsp_o}, 32'd0);
    step();
    rst_ni = 1'b1;
    step();
    check("rst_count", 32'(dut.count_q), 32'd0);
    check("rst_ptr", 32'(dut.ptr_q), 32'd0);

    // Single host
    host_req_i = 2'b01; dev_gnt_i = 1'b1;
    exp_gnt.push_back(0);
    #3;
    check("single_gnt", {30'd0, host_gnt_o}, 32'h1);
    check("single_addr", dev_addr_o, Addr0);
    check("single_be", {28'd0, dev_be_o}, 32'hF);
    step();
    host_req_i = 2'b00; dev_gnt_i = 1'b0;
    dev_rvalid_i = 1'b1; dev_rdata_i = 32'hDEAD_BEEF;
    push_rsp(0, 32'hDEAD_BEEF, 1'b0);
    #3;
    check("single_rvalid", {30'd0, host_rvalid_o}, 32'h1);
    check("single_ptr", 32'(dut.ptr_q), 32'd1);
    step();
    dev_rvalid_i = 1'b0;

    // Spurious response while empty
    step();
    dev_rvalid_i = 1'b1; dev_rdata_i = 32'h0BAD_0BAD;
    spur_exp++;
    #3;
    check("spur_pulse", {31'd0, spurious_rsp_o}, 32'd1);
    check("spur_no_rvalid", {30'd0, host_rvalid_o}, 32'd0);
    step();
    dev_rvalid_i = 1'b0;

    // Contention from ptr=1: grants 1,0,1,0, each answered one cycle later
    host_req_i = 2'b11; dev_gnt_i = 1'b1;
    exp_gnt.push_back(1);
    step();
    dev_rvalid_i = 1'b1; dev_rdata_i = 32'hA000_0001;
    exp_gnt.push_back(0); push_rsp(1, 32'hA000_0001, 1'b0);
    step();
    check("cont_count_b", 32'(dut.count_q), 32'd1);
    dev_rdata_i = 32'hA000_0002; dev_err_i = 1'b1;
    exp_gnt.push_back(1); push_rsp(0, 32'hA000_0002, 1'b1);
    step();
    check("cont_count_c", 32'(dut.count_q), 32'd1);
    dev_rdata_i = 32'hA000_0003; dev_err_i = 1'b0;
    exp_gnt.push_back(0); push_rsp(1, 32'hA000_0003, 1'b0);
    step();
    host_req_i = 2'b00; dev_gnt_i = 1'b0;
    dev_rdata_i = 32'hA000_0004;
    push_rsp(0, 32'hA000_0004, 1'b0);
    step();
    dev_rvalid_i = 1'b0;
    check("cont_count_end", 32'(dut.count_q), 32'd0);

    // Bring ptr back to 0 with a lone host1 transfer
    host_req_i = 2'b10; dev_gnt_i = 1'b1;
    exp_gnt.push_back(1);
    step();
    host_req_i = 2'b00; dev_gnt_i = 1'b0;
    dev_rvalid_i = 1'b1; dev_rdata_i = 32'hB000_0001;
    push_rsp(1, 32'hB000_0001, 1'b0);
    step();
    dev_rvalid_i = 1'b0;
    check("lock_ptr0", 32'(dut.ptr_q), 32'd0);

    // Stall lock: host1 stalled, host0 joins in the second cycle
    host_req_i = 2'b10;
    #3;
    check("lock_addr_c1", dev_addr_o, Addr1);
    step();
    host_req_i = 2'b11;
    #3;
    check("lock_addr_c2", dev_addr_o, Addr1);
    check("lock_nogrant", {30'd0, host_gnt_o}, 32'd0);
    step();
    #3;
    check("lock_addr_c3", dev_addr_o, Addr1);
    step();
    dev_gnt_i = 1'b1;
    exp_gnt.push_back(1);
    #3;
    check("lock_gnt1", {30'd0, host_gnt_o}, 32'h2);
    step();
    host_req_i = 2'b01;
    dev_rvalid_i = 1'b1; dev_rdata_i = 32'hC000_0001;
    exp_gnt.push_back(0); push_rsp(1, 32'hC000_0001, 1'b0);
    #3;
    check("lock_next_addr", dev_addr_o, Addr0);
    step();
    check("pushpop_count", 32'(dut.count_q), 32'd1);
    host_req_i = 2'b00; dev_gnt_i = 1'b0;
    dev_rdata_i = 32'hC000_0002;
    push_rsp(0, 32'hC000_0002, 1'b0);
    step();
    dev_rvalid_i = 1'b0;

    // Full: two grants with no responses block the third request
    host_req_i = 2'b01; dev_gnt_i = 1'b1;
    exp_gnt.push_back(0);
    step();
    exp_gnt.push_back(0);
    step();
    #3;
    check("full_req_low", {31'd0, dev_req_o}, 32'd0);
    step();
    dev_rvalid_i = 1'b1; dev_rdata_i = 32'hD000_0001;
    push_rsp(0, 32'hD000_0001, 1'b0);
    #3;
    check("full_pop_no_unblock", {31'd0, dev_req_o}, 32'd0);
    step();
    dev_rvalid_i = 1'b0;
    exp_gnt.push_back(0);
    #3;
    check("full_reassert", {31'd0, dev_req_o}, 32'd1);
    step();
    host_req_i = 2'b00; dev_gnt_i = 1'b0;
    #3;
    check("full_count2", 32'(dut.count_q), 32'd2);

    // Reset with two outstanding, then a late response
    rst_ni = 1'b0;
    #2;
    check("arst_count", 32'(dut.count_q), 32'd0);
    check("arst_ptr", 32'(dut.ptr_q), 32'd0);
    step();
    rst_ni = 1'b1;
    step();
    dev_rvalid_i = 1'b1; dev_rdata_i = 32'hE000_0001;
    spur_exp++;
    #3;
    check("late_spur", {31'd0, spurious_rsp_o}, 32'd1);
    check("late_no_rvalid", {30'd0, host_rvalid_o}, 32'd0);
    step();
    dev_rvalid_i = 1'b0;
    step();

    check("gnt_queue_drained", 32'(exp_gnt.size()), 32'd0);
    check("rsp_queue_drained", 32'(exp_rsp.size()), 32'd0);
    check("spur_total", 32'(spur_seen), 32'(spur_exp));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
